// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the EX-stage hazard logic and the
// iterative shifter: operands and controls in, status and result out.
interface shift_sequencer_if #(
   parameter int XLEN = 32
);
   logic            start;
   logic [XLEN-1:0] A;
   logic [4:0]      shamt;
   logic [1:0]      shiftSel;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] shiftResult;

   modport master (
      output start, A, shamt, shiftSel, flush,
      input  busy, done, shiftResult
   );

   modport slave (
      input  start, A, shamt, shiftSel, flush,
      output busy, done, shiftResult
   );
endinterface

// File: rtl/shift_sequencer.sv
// Iterative RV32I shifter (SLL/SRL/SRA): STEP bits per clock, registered
// result with a one-cycle done pulse, abortable by a pipeline flush.
module shift_sequencer #(
   parameter int XLEN = 32,
   parameter int STEP = 1
) (
   input logic              clk,
   input logic              rst_n,
   shift_sequencer_if.slave bus
);

   localparam logic [4:0] STEP_AMT = 5'(STEP);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state, state_nx;
   logic [XLEN-1:0] acc, acc_nx;
   logic [XLEN-1:0] result, result_nx;
   logic [4:0]      rem, rem_nx;
   logic [1:0]      sel, sel_nx;
   logic            sign, sign_nx;
   logic [4:0]      k;

   // SRA fills from the sign latched at start, carried as an extra top bit.
   function automatic logic [XLEN-1:0] shift_step(
      input logic [XLEN-1:0] val,
      input logic [1:0]      op,
      input logic            fill,
      input logic [4:0]      amt
   );
      logic signed [XLEN:0] ext;
      ext = {fill, val};
      case (op)
         2'b00:   shift_step = val << amt;
         2'b01:   shift_step = val >> amt;
         2'b10:   shift_step = XLEN'(ext >>> amt);
         default: shift_step = val;
      endcase
   endfunction

   assign k = (rem < STEP_AMT) ? rem : STEP_AMT;

   always_comb begin
      state_nx  = state;
      acc_nx    = acc;
      rem_nx    = rem;
      sel_nx    = sel;
      sign_nx   = sign;
      result_nx = result;
      if (bus.flush) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  acc_nx  = bus.A;
                  rem_nx  = bus.shamt;
                  sel_nx  = bus.shiftSel;
                  sign_nx = bus.A[XLEN-1];
                  if (bus.shamt == 5'd0 || bus.shiftSel == 2'b11) begin
                     state_nx  = DONE;
                     result_nx = bus.A;
                  end else begin
                     state_nx = SHIFT;
                  end
               end
            end
            SHIFT: begin
               acc_nx = shift_step(acc, sel, sign, k);
               rem_nx = rem - k;
               if (rem_nx == 5'd0) begin
                  state_nx  = DONE;
                  result_nx = acc_nx;
               end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         acc    <= '0;
         rem    <= '0;
         sel    <= '0;
         sign   <= 1'b0;
         result <= '0;
      end else begin
         state  <= state_nx;
         acc    <= acc_nx;
         rem    <= rem_nx;
         sel    <= sel_nx;
         sign   <= sign_nx;
         result <= result_nx;
      end
   end

   assign bus.busy        = (state != IDLE);
   assign bus.done        = (state == DONE);
   assign bus.shiftResult = result;

endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle sequencer for the RV32I shift datapath. It accepts one shift operation (SLL/SRL/SRA) per request, performs it iteratively at STEP bits per clock, and returns a registered result with a one-cycle done pulse. It sits beside the ALU in the EX stage, so the pipeline's hazard unit can stall on busy instead of timing a 32-deep combinational shift chain. A pipeline flush aborts the operation in flight.

## Interface
- XLEN, 32: datapath width; fixed at 32 for RV32I.
- STEP, 1: bits shifted per cycle; legal values are 1, 2, 4, 8 and 16.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request; sampled only in IDLE.
- A  in  32  operand; latched when start is accepted.
- shamt  in  5  shift amount; latched when start is accepted.
- shiftSel  in  2  operation: 00 = SLL, 01 = SRL, 10 = SRA, 11 = pass-through. Latched when start is accepted.
- flush  in  1  synchronous abort; highest priority after reset.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse; shiftResult is valid from this cycle.
- shiftResult  out  32  registered result; held until the next completion.

## Operation
- States: IDLE, SHIFT, DONE. Internal registers: acc[31:0], rem[4:0], sel[1:0], sign.
- IDLE, start=1, flush=0:
  - Load acc←A, rem←shamt, sel←shiftSel, sign←A[31].
  - If shamt==0 or shiftSel==11, go to DONE. Otherwise go to SHIFT.
- SHIFT, each edge:
  - k = min(rem, STEP).
  - SLL: acc←acc<<k, zero fill.
  - SRL: acc←acc>>k, zero fill.
  - SRA: acc←acc>>k, filled with sign (the latched A[31]).
  - rem←rem−k. When the new rem is 0, go to DONE.
- DONE: one cycle only, then IDLE.
  - shiftResult is written with acc on the edge that enters DONE.
  - done is registered and equals (state==DONE).
- start is ignored while busy, including in the DONE cycle. There is no queuing; the requester holds start until it sees busy rise.
- Flush:
  - In any state, go to IDLE on the next edge.
  - No done pulse is produced, and shiftResult is not updated.
  - flush together with start in IDLE: the start is dropped.
- Reset (rst_n=0, any time, including mid-operation):
  - State becomes IDLE immediately.
  - busy=0, done=0, shiftResult=0, and acc, rem, sel, sign all become 0.
- Width rules:
  - rem never underflows, because k ≤ rem.
  - shamt=31 with STEP=16 gives steps of 16 then 15.
  - Result equals the single-cycle reference semantics for all shamt 0..31.

## Timing
- Cycle 0 is the cycle in which start is presented in IDLE. N = ceil(shamt/STEP), with N=0 when shamt==0 or shiftSel==11.
- busy is high in cycles 1..N+1.
- done is high in cycle N+1 only. shiftResult is valid from cycle N+1 and holds.
- The earliest next start is accepted in cycle N+2. Throughput is one operation per N+2 cycles.
- Minimum latency is 1 cycle (shamt=0). Maximum latency at STEP=1 is 32 cycles (shamt=31).
- Flush sampled at edge e: busy is low after edge e.
- No combinational path from any input to any output.

## Test plan
- STEP=1, SLL, A=0x0000_0001, shamt=31 -> busy cycles 1–32, done in cycle 32, shiftResult=0x8000_0000.
- STEP=1, A=0x8000_0000, shamt=4:
  - SRA -> done in cycle 5, shiftResult=0xF800_0000.
  - Repeated with SRL -> shiftResult=0x0800_0000.
- shamt=0, A=0x1234_5678, SLL -> done in cycle 1, shiftResult=0x1234_5678.
- shiftSel=11, shamt=9 -> done in cycle 1, shiftResult=A.
- STEP=1, SLL, shamt=10:
  - flush in cycle 3 -> busy low in cycle 4, no done pulse, shiftResult keeps its prior value; a new start in cycle 4 is accepted.
  - rst_n low in cycle 5 -> all outputs 0 immediately.
- STEP=4, SRA, A=0x8000_0000, shamt=7 -> two SHIFT cycles, done in cycle 3, shiftResult=0xFF00_0000.
- start held high through a whole operation -> exactly one operation completes, and the next is accepted in cycle N+2.
